// File: rtl/seg_scan.sv
// Six-digit seven-segment scanner: BLANK gap, LATCH digit from counter, SHOW decoded digit.
// Leading-zero blanking of digit 1 is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan #(
  parameter int SHOW_CYC  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_digit_in,
  output logic [3:0] o_sel,
  output logic [5:0] o_an,
  output logic [7:0] o_seg,
  output logic       o_frame_tick
);

  localparam int MAX_CYC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYC - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  localparam logic [1:0] ST_BLANK = 2'd0;
  localparam logic [1:0] ST_LATCH = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_k;
  logic [3:0]    r_digit;
  logic [5:0]    r_an;
  logic [7:0]    r_seg;
  logic          r_frame_tick;

  logic [2:0]    w_k_next;
  logic [5:0]    w_an_on;

  // Decimal points sit after digits 2 and 4 to form HH.MM.SS.
  function automatic logic [7:0] seg_decode(input logic [3:0] d, input logic [2:0] k);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    if (k == 3'd2 || k == 3'd4) s[7] = 1'b0;
`ifdef SEG_SCAN_LZB_EN
    if (k == 3'd1 && d == 4'd0) s = 8'hFF;
`endif
    return s;
  endfunction

  assign w_k_next = (r_k == 3'd6) ? 3'd1 : r_k + 3'd1;
  assign w_an_on  = ~(6'b000001 << (r_k - 3'd1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_BLANK;
      r_cnt        <= '0;
      r_k          <= 3'd1;
      r_digit      <= 4'd0;
      r_an         <= 6'h3F;
      r_seg        <= 8'hFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= 1'b0;
      case (r_state)
        ST_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            r_state <= ST_LATCH;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        // The display register is loaded straight from the sampled digit so
        // segments and enable turn on together on the LATCH->SHOW edge.
        ST_LATCH: begin
          r_digit <= i_digit_in;
          r_seg   <= seg_decode(i_digit_in, r_k);
          r_an    <= w_an_on;
          r_state <= ST_SHOW;
          r_cnt   <= '0;
        end
        ST_SHOW: begin
          if (r_cnt == SHOW_LAST) begin
            r_state      <= ST_BLANK;
            r_cnt        <= '0;
            r_an         <= 6'h3F;
            r_seg        <= 8'hFF;
            r_k          <= w_k_next;
            r_frame_tick <= (r_k == 3'd6);
          end else begin
            r_cnt <= r_cnt + 1'b1;
            r_seg <= seg_decode(r_digit, r_k);
          end
        end
        default: begin
          r_state <= ST_BLANK;
          r_cnt   <= '0;
          r_an    <= 6'h3F;
          r_seg   <= 8'hFF;
        end
      endcase
    end
  end

  assign o_sel        = {1'b0, r_k};
  assign o_an         = r_an;
  assign o_seg        = r_seg;
  assign o_frame_tick = r_frame_tick;

endmodule
